// File: rtl/imm_enc_pkg.sv
// Shared types and field layout for the RV32I immediate encoder.
// The IMM_ENC_BJ_EN build macro is consumed by the files that import this package.
package imm_enc_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned OPCODE_W   = 7;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned RD_W       = 5;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned FUNCT3_W   = 3;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS1_W      = 5;
    localparam int unsigned RS2_LSB    = 20;
    localparam int unsigned RS2_W      = 5;
    localparam int unsigned IMM_W      = 32;

    typedef struct packed {
        imm_src_e             imm_src;
        logic [OPCODE_W-1:0]  opcode;
        logic [FUNCT3_W-1:0]  funct3;
        logic [RD_W-1:0]      rd;
        logic [RS1_W-1:0]     rs1;
        logic [RS2_W-1:0]     rs2;
        logic [IMM_W-1:0]     imm;
    } imm_req_t;

    // True when value[31:lsb] are all copies of the sign bit.
    function automatic logic upper_uniform(input logic [IMM_W-1:0] value, input int unsigned lsb);
        logic same;
        same = 1'b1;
        for (int unsigned i = 0; i < IMM_W; i++) begin
            if (i >= lsb && value[i] != value[IMM_W-1]) begin
                same = 1'b0;
            end
        end
        return same;
    endfunction

endpackage

// File: rtl/imm_range_check.sv
// Combinational check that an immediate fits its RV32I encoding.
// B/J formats are accepted only when IMM_ENC_BJ_EN is defined.
module imm_range_check
    import imm_enc_pkg::*;
(
    input  imm_src_e          imm_src,
    input  logic [IMM_W-1:0]  imm,
    output logic              fits
);

    logic unused_low;
    assign unused_low = ^imm[10:0];

    always_comb begin
        fits = 1'b0;
        unique case (imm_src)
            IMM_I,
            IMM_S: fits = upper_uniform(imm, 11);
`ifdef IMM_ENC_BJ_EN
            IMM_B: fits = upper_uniform(imm, 12) && !imm[0];
            IMM_J: fits = upper_uniform(imm, 20) && !imm[0];
            default: fits = 1'b0;
`else
            default: fits = 1'b0;
`endif
        endcase
    end

endmodule

// File: rtl/instr_imm_encoder.sv
// Two-stage valid/ready encoder packing opcode, registers and immediate into an RV32I word.
// Define IMM_ENC_BJ_EN to enable B/J encodings; otherwise they yield instr=0 with out_err set.
module instr_imm_encoder
    import imm_enc_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            imm_src,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [31:0]           imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           instr,
    output logic                  out_err,
    output logic [ERR_CNT_W-1:0]  err_count
);

    imm_req_t    in_req;
    imm_req_t    s1_req;
    logic        s1_valid;
    logic        s1_err;
    logic        s2_valid;
    logic        s1_load;
    logic        s2_load;
    logic        fits;
    logic [31:0] word;
    logic        unused_imm_hi;

    assign in_req = '{
        imm_src: imm_src_e'(imm_src),
        opcode:  opcode,
        funct3:  funct3,
        rd:      rd,
        rs1:     rs1,
        rs2:     rs2,
        imm:     imm
    };

    imm_range_check u_range_check (
        .imm_src (in_req.imm_src),
        .imm     (in_req.imm),
        .fits    (fits)
    );

    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid;

    assign unused_imm_hi = ^s1_req.imm[31:12];

    always_comb begin
        word = '0;
        word[OPCODE_LSB +: OPCODE_W] = s1_req.opcode;
        unique case (s1_req.imm_src)
            IMM_I: begin
                word[RD_LSB +: RD_W]         = s1_req.rd;
                word[FUNCT3_LSB +: FUNCT3_W] = s1_req.funct3;
                word[RS1_LSB +: RS1_W]       = s1_req.rs1;
                word[31:20]                  = s1_req.imm[11:0];
            end
            IMM_S: begin
                word[11:7]                   = s1_req.imm[4:0];
                word[FUNCT3_LSB +: FUNCT3_W] = s1_req.funct3;
                word[RS1_LSB +: RS1_W]       = s1_req.rs1;
                word[RS2_LSB +: RS2_W]       = s1_req.rs2;
                word[31:25]                  = s1_req.imm[11:5];
            end
`ifdef IMM_ENC_BJ_EN
            IMM_B: begin
                word[7]                      = s1_req.imm[11];
                word[11:8]                   = s1_req.imm[4:1];
                word[FUNCT3_LSB +: FUNCT3_W] = s1_req.funct3;
                word[RS1_LSB +: RS1_W]       = s1_req.rs1;
                word[RS2_LSB +: RS2_W]       = s1_req.rs2;
                word[30:25]                  = s1_req.imm[10:5];
                word[31]                     = s1_req.imm[12];
            end
            IMM_J: begin
                word[RD_LSB +: RD_W]         = s1_req.rd;
                word[19:12]                  = s1_req.imm[19:12];
                word[20]                     = s1_req.imm[11];
                word[30:21]                  = s1_req.imm[10:1];
                word[31]                     = s1_req.imm[20];
            end
            default: ;
`else
            default: word = '0;
`endif
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_req   <= '0;
            s1_err   <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_req <= in_req;
                s1_err <= !fits;
            end
        end
    end

    // Output word only changes when stage 2 is free to load, so it holds during a stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            instr    <= '0;
            out_err  <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                instr   <= word;
                out_err <= s1_err;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (s2_valid && out_ready && out_err && err_count != '1) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_imm_encoder.sv
// Randomized self-checking bench for instr_imm_encoder with a scoreboard reference model.
// Honours IMM_ENC_BJ_EN the same way the design does.
module tb_instr_imm_encoder;

    localparam int unsigned ERR_CNT_W = 8;
    localparam int unsigned CNT_MAX   = (1 << ERR_CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           imm_src;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [31:0]          imm;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          instr;
    logic                 out_err;
    logic [ERR_CNT_W-1:0] err_count;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned model_cnt = 0;
    int unsigned delivered = 0;
    logic [32:0] sb[$];

    int bnd[14] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                    1048574, 1048575, -1048576, -1048578, 0, -1};

    always #5 clk = ~clk;

    instr_imm_encoder #(.ERR_CNT_W(ERR_CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_src   (imm_src),
        .opcode    (opcode),
        .funct3    (funct3),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: legal ranges as signed integers, fields placed with shifts and masks.
    function automatic logic [32:0] ref_word(input logic [1:0] src, input logic [6:0] op,
                                             input logic [2:0] f3, input logic [4:0] d,
                                             input logic [4:0] s1, input logic [4:0] s2,
                                             input logic [31:0] v);
        longint sv;
        logic   ok;
        logic [31:0] w;
        sv = longint'($signed(v));
        ok = 1'b0;
        w  = '0;
        case (src)
            2'd0: begin
                ok = (sv >= -2048) && (sv <= 2047);
                w  = ((v & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'(op);
            end
            2'd1: begin
                ok = (sv >= -2048) && (sv <= 2047);
                w  = (((v >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12)
                   | ((v & 32'h1F) << 7) | 32'(op);
            end
`ifdef IMM_ENC_BJ_EN
            2'd2: begin
                ok = (sv >= -4096) && (sv <= 4095) && ((v % 32'd2) == 0);
                w  = (((v >> 12) & 32'h1) << 31) | (((v >> 5) & 32'h3F) << 25) | (32'(s2) << 20)
                   | (32'(s1) << 15) | (32'(f3) << 12) | (((v >> 1) & 32'hF) << 8)
                   | (((v >> 11) & 32'h1) << 7) | 32'(op);
            end
            default: begin
                ok = (sv >= -1048576) && (sv <= 1048575) && ((v % 32'd2) == 0);
                w  = (((v >> 20) & 32'h1) << 31) | (((v >> 1) & 32'h3FF) << 21)
                   | (((v >> 11) & 32'h1) << 20) | (((v >> 12) & 32'hFF) << 12)
                   | (32'(d) << 7) | 32'(op);
            end
`else
            default: begin
                ok = 1'b0;
                w  = '0;
            end
`endif
        endcase
        return {!ok, w};
    endfunction

    always @(negedge clk) begin
        logic [32:0] e;
        if (reset) begin
            sb.delete();
            model_cnt <= 0;
        end else begin
            check("err_count", 32'(err_count), model_cnt);
            if (in_valid && in_ready)
                sb.push_back(ref_word(imm_src, opcode, funct3, rd, rs1, rs2, imm));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("instr", instr, e[31:0]);
                    check("out_err", 32'(out_err), 32'(e[32]));
                    delivered <= delivered + 1;
                    if (e[32] && model_cnt < CNT_MAX) model_cnt <= model_cnt + 1;
                end
            end
        end
    end

    task automatic set_req(input logic [1:0] src, input logic [6:0] op, input logic [2:0] f3,
                           input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [31:0] v);
        imm_src = src; opcode = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2; imm = v;
    endtask

    task automatic rand_req();
        logic [31:0] v;
        case ($urandom % 4)
            0: v = $urandom;
            1: v = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: v = 32'(bnd[$urandom % 14]);
            default: v = 32'($urandom_range(0, 4194303)) - 32'd2097152;
        endcase
        set_req(2'($urandom), 7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), v);
    endtask

    // Returns at posedge+1 of the accepting edge; in_valid is left high.
    task automatic send();
        logic rdy;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) return;
        end
        check("accept_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0 && !out_valid) return;
            @(posedge clk);
            #1;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        int unsigned base;
        logic acc;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_req(2'd0, 7'h0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;

        // I-type example with two-cycle latency
        set_req(2'd0, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF);
        send();
        in_valid = 1'b0;
        check("t1_lat1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("t1_lat2", 32'(out_valid), 32'd1);
        check("t1_instr", instr, 32'hFFF1_0093);
        check("t1_err", 32'(out_err), 32'd0);
        drain();

        set_req(2'd1, 7'h23, 3'b010, 5'd0, 5'd2, 5'd5, 32'd8);
        send();
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("t2_instr", instr, 32'h0051_2423);
        check("t2_err", 32'(out_err), 32'd0);
        drain();

        check("t3_cnt0", 32'(err_count), 32'd0);
        set_req(2'd0, 7'h13, 3'd0, 5'd3, 5'd4, 5'd0, 32'd2048);
        send();
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("t3_err", 32'(out_err), 32'd1);
        check("t3_imm_field", 32'(instr[31:20]), 32'h800);
        @(posedge clk); #1;
        check("t3_cnt1", 32'(err_count), 32'd1);
        drain();

        set_req(2'd2, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
        send();
        in_valid = 1'b0;
        @(posedge clk); #1;
`ifdef IMM_ENC_BJ_EN
        check("t5_b_instr", instr, 32'hFE00_0EE3);
        check("t5_b_err", 32'(out_err), 32'd0);
`else
        check("t5_b_instr", instr, 32'h0);
        check("t5_b_err", 32'(out_err), 32'd1);
`endif
        drain();
        set_req(2'd2, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'd3);
        send();
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("t5_b_odd_err", 32'(out_err), 32'd1);
        drain();

        // Backpressure: two words fill the pipe, third must wait
        base = delivered;
        out_ready = 1'b0;
        set_req(2'd0, 7'h13, 3'd1, 5'd1, 5'd1, 5'd0, 32'd100);
        send();
        set_req(2'd1, 7'h23, 3'd2, 5'd0, 5'd2, 5'd3, 32'd200);
        send();
        set_req(2'd0, 7'h13, 3'd3, 5'd4, 5'd5, 5'd0, 32'd300);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        held = instr;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_stable", instr, held);
            check("bp_stall_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        send();
        set_req(2'd1, 7'h23, 3'd4, 5'd0, 5'd6, 5'd7, 32'hFFFF_F800);
        send();
        in_valid = 1'b0;
        drain();
        check("bp_delivered", delivered - base, 32'd4);

        in_valid = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc || !in_valid) begin
                if ($urandom % 4 != 0) begin
                    rand_req();
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom % 4) != 0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Saturation of the error counter
        set_req(2'd0, 7'h13, 3'd0, 5'd1, 5'd1, 5'd0, 32'h0010_0000);
        for (int i = 0; i < (1 << ERR_CNT_W) + 3; i++) send();
        in_valid = 1'b0;
        drain();
        check("sat_cnt", 32'(err_count), 32'hFF);

        // Reset with words in flight
        out_ready = 1'b0;
        set_req(2'd0, 7'h13, 3'd0, 5'd1, 5'd1, 5'd0, 32'd4096);
        send();
        set_req(2'd1, 7'h23, 3'd0, 5'd0, 5'd1, 5'd2, 32'd5);
        send();
        in_valid = 1'b0;
        check("t6_inflight", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_err_count", 32'(err_count), 32'd0);
        check("t6_instr", instr, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            check("t6_no_stale", 32'(out_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
